// File: rtl/ram_stride_sequencer.sv
// Accumulator-addressed scratch RAM sequencer: walks a base/stride address sequence
// and performs READ stream-out, WRITE pattern-fill or RMW add-in-place per command.
module ram_stride_sequencer #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 4,
  parameter int    ACC_W     = 20,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ACC_W-1:0]  base,
  input  logic [ACC_W-1:0]  stride,
  input  logic              carry_in,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ACC_W-1:0]  acc,
  output logic              cout
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, WB, DONE} state_t;

  state_t              state, state_next;
  logic [1:0]          mode_q;
  logic [ACC_W-1:0]    stride_q;
  logic                cin_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W:0]     remain;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr;
  logic [ACC_W:0]      step_sum;
  logic                is_write, is_rmw, last;

  // Memory cleared at configuration; RAM contents are never touched by reset.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_comb begin
    addr     = acc[ADDR_W-1:0];
    step_sum = {1'b0, acc} + {1'b0, stride_q} + (ACC_W+1)'(cin_q);
    is_write = (mode_q == 2'd1);
    is_rmw   = (mode_q == 2'd2);
    last     = (remain == (ADDR_W+1)'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (count == '0) ? DONE : RUN;
      RUN: begin
        if (is_rmw)    state_next = WB;
        else if (last) state_next = DONE;
      end
      WB:      state_next = last ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == WB);
    done = (state == DONE);
  end

  // rd_data doubles as the RMW operand register: captured in RUN, consumed in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      stride_q <= '0;
      cin_q    <= 1'b0;
      wdata_q  <= '0;
      remain   <= '0;
      acc      <= '0;
      cout     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            stride_q <= stride;
            cin_q    <= carry_in;
            wdata_q  <= wdata;
            remain   <= count;
            acc      <= base;
            cout     <= 1'b0;
          end
        end
        RUN: begin
          if (!is_write) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[addr];
            rd_addr  <= addr;
          end
          if (!is_rmw) begin
            acc    <= step_sum[ACC_W-1:0];
            cout   <= cout | step_sum[ACC_W];
            remain <= remain - (ADDR_W+1)'(1);
          end
        end
        WB: begin
          acc    <= step_sum[ACC_W-1:0];
          cout   <= cout | step_sum[ACC_W];
          remain <= remain - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RUN && is_write) mem[addr] <= wdata_q;
    else if (state == WB)         mem[addr] <= rd_data + wdata_q;
  end

endmodule

// File: tb/tb_ram_stride_sequencer.sv
// Scoreboard bench for ram_stride_sequencer: a reference model predicts read beats,
// handshake timing and final accumulator state from the command arithmetic.
module tb_ram_stride_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = '0;
    logic [ACC_W-1:0]  base = '0;
    logic [ACC_W-1:0]  stride = '0;
    logic              carry_in = 1'b0;
    logic [ADDR_W:0]   count = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              busy, done, rd_valid, cout;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W-1:0]  acc;

    ram_stride_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base), .stride(stride),
        .carry_in(carry_in), .count(count), .wdata(wdata), .busy(busy), .done(done),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .acc(acc), .cout(cout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [ADDR_W+DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] model [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every rd_valid beat must match the oldest predicted beat.
    initial begin
        logic [ADDR_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && rd_valid) begin
                chk("rd_beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    chk("rd_data", 32'(rd_data), 32'(e[DATA_W-1:0]));
                end
            end
        end
    end

    task automatic scramble();
        mode     = 2'($urandom);
        base     = ACC_W'($urandom);
        stride   = ACC_W'($urandom);
        carry_in = 1'($urandom);
        count    = (ADDR_W+1)'($urandom);
        wdata    = DATA_W'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] m, input logic [ACC_W-1:0] b, input logic [ACC_W-1:0] s,
                           input logic ci, input logic [ADDR_W:0] n, input logic [DATA_W-1:0] wd,
                           input bit hold);
        longint unsigned stp, av, tot;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] old;
        logic [ACC_W-1:0] eacc;
        logic ecout;
        int dur;
        stp = longint'(s) + longint'(ci);
        for (int i = 0; i < int'(n); i++) begin
            av = longint'(b) + longint'(i) * stp;
            a  = av[ADDR_W-1:0];
            old = model[a];
            if (m == 2'd1) begin
                model[a] = wd;
            end else if (m == 2'd2) begin
                sb.push_back({a, old});
                model[a] = old + wd;
            end else begin
                sb.push_back({a, old});
            end
        end
        tot   = longint'(b) + longint'(n) * stp;
        eacc  = tot[ACC_W-1:0];
        ecout = (tot >= (64'd1 << ACC_W));
        dur   = (m == 2'd2) ? 2 * int'(n) : int'(n);

        @(negedge clk);
        mode = m; base = b; stride = s; carry_in = ci; count = n; wdata = wd; start = 1'b1;
        for (int k = 1; k <= dur + 1; k++) begin
            @(negedge clk);
            scramble();
            start = hold;
            chk("busy", 32'(busy), 32'(k <= dur));
            chk("done", 32'(done), 32'(k == dur + 1));
            if (k == dur + 1) begin
                chk("acc", 32'(acc), 32'(eacc));
                chk("cout", 32'(cout), 32'(ecout));
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_acc"}, 32'(acc), 32'd0);
        chk({tag, "_cout"}, 32'(cout), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rm;
        logic [ACC_W-1:0] rb, rs;
        for (int i = 0; i < 16; i++) model[i] = '0;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Full-range fill then read back
        run_cmd(2'd1, 20'd0, 20'd1, 1'b0, 5'd16, 8'h73, 1'b0);
        run_cmd(2'd0, 20'd0, 20'd1, 1'b0, 5'd16, 8'h00, 1'b0);

        // Reset in the middle of a READ run aborts with everything cleared
        mon_en = 1'b0;
        @(negedge clk);
        mode = 2'd0; base = 20'd3; stride = 20'd1; carry_in = 1'b0; count = 5'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
        end
        sb.delete();
        mon_en = 1'b1;

        run_cmd(2'd0, 20'd0, 20'd0, 1'b1, 5'd4, 8'h00, 1'b0);
        run_cmd(2'd1, 20'd5, 20'd0, 1'b0, 5'd1, 8'd25, 1'b0);
        run_cmd(2'd2, 20'd5, 20'd0, 1'b0, 5'd3, 8'd2, 1'b0);
        run_cmd(2'd0, 20'd5, 20'd0, 1'b0, 5'd1, 8'h00, 1'b0);
        run_cmd(2'd0, 20'hFFFFE, 20'd1, 1'b0, 5'd4, 8'h00, 1'b0);
        run_cmd(2'd0, 20'd3, 20'd2, 1'b0, 5'd0, 8'h00, 1'b0);
        run_cmd(2'd1, 20'd7, 20'd3, 1'b1, 5'd5, 8'hA5, 1'b1);
        run_cmd(2'd3, 20'd7, 20'd4, 1'b0, 5'd6, 8'h00, 1'b1);
        run_cmd(2'd2, 20'd2, 20'hFFFFF, 1'b1, 5'd3, 8'hF0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            rm = 2'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? ACC_W'(20'hFFFF0 + $urandom_range(0, 15)) : ACC_W'($urandom);
            rs = ($urandom_range(0, 1) == 0) ? ACC_W'($urandom_range(0, 3)) : ACC_W'($urandom);
            run_cmd(rm, rb, rs, 1'($urandom), (ADDR_W+1)'($urandom_range(0, 16)),
                    DATA_W'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
